mem_access_unit: RTL and testbench

//  MEM-stage load/store unit, directly downstream of the EX/MEM pipeline register.

---
 rtl/rv32_mem_pkg.sv | 60 ++++++
 rtl/mem_load_extend.sv | 33 +++
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access codes,
// FSM encoding, byte-lane patterns and small decode helpers.
package rv32_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Access size of a load; reserved funct3 codes behave as a word load.
  function automatic logic [1:0] load_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: load_size = SZ_B;
      F3_LH, F3_LHU: load_size = SZ_H;
      F3_LW:         load_size = SZ_W;
      default:       load_size = SZ_W;
    endcase
  endfunction

  // Reserved store size 2'b11 is treated as a word store.
  function automatic logic [1:0] store_size(input logic [1:0] s);
    case (s)
      SZ_B:    store_size = SZ_B;
      SZ_H:    store_size = SZ_H;
      default: store_size = SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] be_pattern(input logic [1:0] size);
    case (size)
      SZ_B:    be_pattern = BE_BYTE;
      SZ_H:    be_pattern = BE_HALF;
      default: be_pattern = BE_WORD;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    is_aligned = 1'b1;
      SZ_H:    is_aligned = ~off[0];
      default: is_aligned = (off == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Selects the addressed byte/halfword from a memory word and extends it
// according to the load funct3. Purely combinational.
module mem_load_extend
  import rv32_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by sign/zero extension.
  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LHU:  result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one handshaked data-memory access per
// EX/MEM op, stalls the upstream pipe while it is outstanding and returns the
// extended load result.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for an op; aligned op issues, misaligned op pulses MISALIGN
//   ST_ACCESS | request held on the bus until DMEM_ACK or wait-counter timeout
//   ST_DONE   | one unstalled cycle so EX/MEM advances; inputs ignored
module mem_access_unit
  import rv32_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
)
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] MEM_ALU_OUT,
  input  logic [31:0] MEM_REG_DATA2,
  input  logic [3:0]  MEM_DATA_MEM_READ,
  input  logic [2:0]  MEM_DATA_MEM_WRITE,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BYTE_EN,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  output logic [31:0] LOAD_DATA,
  output logic        STALL,
  output logic        MISALIGN,
  output logic        MEM_FAULT
);

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic [31:0]          load_data_q, load_data_d;
  logic                 misalign_q, misalign_d;
  logic                 fault_q, fault_d;
  logic [1:0]           offset_q, offset_d;
  logic [2:0]           funct3_q, funct3_d;

  logic        store_en, load_en, op_valid, aligned, stall_c;
  logic [1:0]  acc_size;
  logic [31:0] store_lanes;
  logic [31:0] ext_data;

  mem_load_extend u_load_extend (
    .rdata  (DMEM_RDATA),
    .offset (offset_q),
    .funct3 (funct3_q),
    .result (ext_data)
  );

  // Op decode, alignment check and store lane replication.
  always_comb begin
    store_en = MEM_DATA_MEM_WRITE[2];
    load_en  = MEM_DATA_MEM_READ[3];
    op_valid = store_en | load_en;
    acc_size = store_en ? store_size(MEM_DATA_MEM_WRITE[1:0])
                        : load_size(MEM_DATA_MEM_READ[2:0]);
    aligned  = is_aligned(acc_size, MEM_ALU_OUT[1:0]);
    case (acc_size)
      SZ_B:    store_lanes = {4{MEM_REG_DATA2[7:0]}};
      SZ_H:    store_lanes = {2{MEM_REG_DATA2[15:0]}};
      default: store_lanes = MEM_REG_DATA2;
    endcase
  end

  // Next-state, request and result logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    read_d      = read_q;
    write_d     = write_q;
    load_data_d = load_data_q;
    offset_d    = offset_q;
    funct3_d    = funct3_q;
    misalign_d  = 1'b0;
    fault_d     = 1'b0;
    stall_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          if (aligned) begin
            stall_c  = 1'b1;
            addr_d   = {MEM_ALU_OUT[31:2], 2'b00};
            be_d     = be_pattern(acc_size) << MEM_ALU_OUT[1:0];
            offset_d = MEM_ALU_OUT[1:0];
            funct3_d = MEM_DATA_MEM_READ[2:0];
            read_d   = ~store_en;
            write_d  = store_en;
            if (store_en) begin
              wdata_d = store_lanes;
            end
            cnt_d    = CNT_LOAD;
            state_d  = ST_ACCESS;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        stall_c = 1'b1;
        if (DMEM_ACK) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (read_q) begin
            load_data_d = ext_data;
          end
          state_d = ST_DONE;
        end else if (cnt_q == '0) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          fault_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      load_data_q <= '0;
      offset_q    <= '0;
      funct3_q    <= '0;
      misalign_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      read_q      <= read_d;
      write_q     <= write_d;
      load_data_q <= load_data_d;
      offset_q    <= offset_d;
      funct3_q    <= funct3_d;
      misalign_q  <= misalign_d;
      fault_q     <= fault_d;
    end
  end

  // STALL is combinational; it is forced low while reset is asserted.
  assign STALL        = stall_c & RESET;
  assign DMEM_ADDR    = addr_q;
  assign DMEM_WDATA   = wdata_q;
  assign DMEM_BYTE_EN = be_q;
  assign DMEM_READ    = read_q;
  assign DMEM_WRITE   = write_q;
  assign LOAD_DATA    = load_data_q;
  assign MISALIGN     = misalign_q;
  assign MEM_FAULT    = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: inputs are driven 1 time unit after
// each rising edge, outputs are sampled 1 time unit later.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] MEM_ALU_OUT;
  logic [31:0] MEM_REG_DATA2;
  logic [3:0]  MEM_DATA_MEM_READ;
  logic [2:0]  MEM_DATA_MEM_WRITE;
  logic [31:0] DMEM_RDATA;
  logic        DMEM_ACK;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WDATA;
  logic [3:0]  DMEM_BYTE_EN;
  logic        DMEM_READ;
  logic        DMEM_WRITE;
  logic [31:0] LOAD_DATA;
  logic        STALL;
  logic        MISALIGN;
  logic        MEM_FAULT;

  int errors = 0;
  int checks = 0;
  int stall_cnt;
  int req_cnt;

  mem_access_unit #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(5)) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .MEM_ALU_OUT        (MEM_ALU_OUT),
    .MEM_REG_DATA2      (MEM_REG_DATA2),
    .MEM_DATA_MEM_READ  (MEM_DATA_MEM_READ),
    .MEM_DATA_MEM_WRITE (MEM_DATA_MEM_WRITE),
    .DMEM_RDATA         (DMEM_RDATA),
    .DMEM_ACK           (DMEM_ACK),
    .DMEM_ADDR          (DMEM_ADDR),
    .DMEM_WDATA         (DMEM_WDATA),
    .DMEM_BYTE_EN       (DMEM_BYTE_EN),
    .DMEM_READ          (DMEM_READ),
    .DMEM_WRITE         (DMEM_WRITE),
    .LOAD_DATA          (LOAD_DATA),
    .STALL              (STALL),
    .MISALIGN           (MISALIGN),
    .MEM_FAULT          (MEM_FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic no_op();
    MEM_DATA_MEM_READ  = 4'b0000;
    MEM_DATA_MEM_WRITE = 3'b000;
    DMEM_ACK           = 1'b0;
  endtask

  initial begin
    RESET         = 1'b0;
    MEM_ALU_OUT   = 32'h0;
    MEM_REG_DATA2 = 32'h0;
    DMEM_RDATA    = 32'h0;
    no_op();

    // Reset state
    cyc(); cyc();
    settle();
    check("rst_addr",  DMEM_ADDR, 32'h0);
    check("rst_wdata", DMEM_WDATA, 32'h0);
    check("rst_be",    {28'h0, DMEM_BYTE_EN}, 32'h0);
    check("rst_req",   {30'h0, DMEM_READ, DMEM_WRITE}, 32'h0);
    check("rst_load",  LOAD_DATA, 32'h0);
    check("rst_flags", {29'h0, STALL, MISALIGN, MEM_FAULT}, 32'h0);
    cyc();
    RESET = 1'b1;

    // SW 0x100, zero-wait
    cyc();
    MEM_DATA_MEM_WRITE = 3'b110; MEM_ALU_OUT = 32'h100; MEM_REG_DATA2 = 32'hDEADBEEF;
    settle();
    check("sw_stall_t", STALL, 1);
    cyc();
    no_op(); DMEM_ACK = 1'b1;
    settle();
    check("sw_addr",   DMEM_ADDR, 32'h100);
    check("sw_be",     DMEM_BYTE_EN, 4'b1111);
    check("sw_wdata",  DMEM_WDATA, 32'hDEADBEEF);
    check("sw_req",    {DMEM_READ, DMEM_WRITE}, 2'b01);
    check("sw_stall_t1", STALL, 1);
    cyc();
    DMEM_ACK = 1'b0;
    settle();
    check("sw_stall_t2", STALL, 0);
    check("sw_req_drop", DMEM_WRITE, 0);
    cyc();
    settle();
    check("sw_idle_stall", STALL, 0);

    // LB 0x203 with three wait cycles
    stall_cnt = 0;
    cyc();
    MEM_DATA_MEM_READ = 4'b1000; MEM_ALU_OUT = 32'h203;
    settle();
    stall_cnt += int'(STALL);
    cyc();
    no_op();
    settle();
    stall_cnt += int'(STALL);
    check("lb_addr", DMEM_ADDR, 32'h200);
    check("lb_be",   DMEM_BYTE_EN, 4'b1000);
    check("lb_req",  {DMEM_READ, DMEM_WRITE}, 2'b10);
    cyc(); settle(); stall_cnt += int'(STALL);
    cyc(); settle(); stall_cnt += int'(STALL);
    check("lb_req_held", DMEM_READ, 1);
    cyc();
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'h80123456;
    settle();
    stall_cnt += int'(STALL);
    cyc();
    DMEM_ACK = 1'b0;
    settle();
    stall_cnt += int'(STALL);
    check("lb_load",   LOAD_DATA, 32'hFFFFFF80);
    check("lb_stalls", stall_cnt, 5);
    check("lb_req_drop", DMEM_READ, 0);

    // LHU 0x202, zero-wait
    cyc();
    MEM_DATA_MEM_READ = 4'b1101; MEM_ALU_OUT = 32'h202;
    cyc();
    no_op(); DMEM_ACK = 1'b1; DMEM_RDATA = 32'h80011234;
    settle();
    check("lhu_be", DMEM_BYTE_EN, 4'b1100);
    cyc();
    DMEM_ACK = 1'b0;
    settle();
    check("lhu_load", LOAD_DATA, 32'h00008001);

    // LH 0x000, sign extension of the low half
    cyc();
    MEM_DATA_MEM_READ = 4'b1001; MEM_ALU_OUT = 32'h0;
    cyc();
    no_op(); DMEM_ACK = 1'b1; DMEM_RDATA = 32'h12348001;
    cyc();
    DMEM_ACK = 1'b0;
    settle();
    check("lh_load", LOAD_DATA, 32'hFFFF8001);

    // SB 0x1, upper rs2 bits must not leak
    cyc();
    MEM_DATA_MEM_WRITE = 3'b100; MEM_ALU_OUT = 32'h1; MEM_REG_DATA2 = 32'h123456AB;
    cyc();
    no_op(); DMEM_ACK = 1'b1;
    settle();
    check("sb_wdata", DMEM_WDATA, 32'hABABABAB);
    check("sb_be",    DMEM_BYTE_EN, 4'b0010);
    check("sb_addr",  DMEM_ADDR, 32'h0);
    cyc();
    DMEM_ACK = 1'b0;
    check("sb_no_load_update", LOAD_DATA, 32'hFFFF8001);

    // SH 0x2 with a simultaneous load request: store wins
    cyc();
    MEM_DATA_MEM_WRITE = 3'b101; MEM_DATA_MEM_READ = 4'b1010;
    MEM_ALU_OUT = 32'h2; MEM_REG_DATA2 = 32'h1234CAFE;
    cyc();
    no_op(); DMEM_ACK = 1'b1; DMEM_RDATA = 32'h0;
    settle();
    check("sh_prio_req", {DMEM_READ, DMEM_WRITE}, 2'b01);
    check("sh_wdata",    DMEM_WDATA, 32'hCAFECAFE);
    check("sh_be",       DMEM_BYTE_EN, 4'b1100);
    cyc();
    DMEM_ACK = 1'b0;
    settle();
    check("sh_prio_load_kept", LOAD_DATA, 32'hFFFF8001);

    // LW 0x102 misaligned
    cyc();
    MEM_DATA_MEM_READ = 4'b1010; MEM_ALU_OUT = 32'h102;
    settle();
    check("mis_stall_t", STALL, 0);
    cyc();
    no_op();
    settle();
    check("mis_pulse", MISALIGN, 1);
    check("mis_no_req", DMEM_READ, 0);
    check("mis_stall_t1", STALL, 0);
    check("mis_load_kept", LOAD_DATA, 32'hFFFF8001);
    cyc();
    settle();
    check("mis_pulse_end", MISALIGN, 0);

    // ACK while idle is ignored
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'h77777777;
    cyc();
    DMEM_ACK = 1'b0;
    settle();
    check("idle_ack_ignored", LOAD_DATA, 32'hFFFF8001);

    // Store with no ACK: 16 request cycles then fault
    cyc();
    MEM_DATA_MEM_WRITE = 3'b110; MEM_ALU_OUT = 32'h300; MEM_REG_DATA2 = 32'h5;
    req_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      no_op();
      settle();
      req_cnt += int'(DMEM_WRITE & STALL);
    end
    check("to_req_cycles", req_cnt, 16);
    cyc();
    settle();
    check("to_fault", MEM_FAULT, 1);
    check("to_req_drop", DMEM_WRITE, 0);
    check("to_done_stall", STALL, 0);
    cyc();
    settle();
    check("to_fault_end", MEM_FAULT, 0);

    // Reset during ACCESS with ACK present
    cyc();
    MEM_DATA_MEM_READ = 4'b1010; MEM_ALU_OUT = 32'h400;
    cyc();
    no_op(); RESET = 1'b0; DMEM_ACK = 1'b1; DMEM_RDATA = 32'h11111111;
    settle();
    check("rst_mid_stall_low", STALL, 0);
    cyc();
    RESET = 1'b1; DMEM_ACK = 1'b0;
    settle();
    check("rstm_req",   {DMEM_READ, DMEM_WRITE}, 2'b00);
    check("rstm_addr",  DMEM_ADDR, 32'h0);
    check("rstm_load",  LOAD_DATA, 32'h0);
    check("rstm_flags", {STALL, MISALIGN, MEM_FAULT}, 3'b000);

    // Unit back in IDLE: a fresh LW completes normally
    cyc();
    MEM_DATA_MEM_READ = 4'b1010; MEM_ALU_OUT = 32'h0;
    settle();
    check("post_rst_stall", STALL, 1);
    cyc();
    no_op(); DMEM_ACK = 1'b1; DMEM_RDATA = 32'h55AA55AA;
    cyc();
    DMEM_ACK = 1'b0;
    settle();
    check("post_rst_lw", LOAD_DATA, 32'h55AA55AA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
